// File: rtl/mem_access_if.sv
// Bundle of the CPU request/response handshake and the word-wide data memory
// port. The master side is the memory access unit; the slave side is the
// environment around it (CPU datapath plus the memory itself).
interface mem_access_if;
    // request from the CPU datapath
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic        req_byte;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;

    // single-cycle completion back to the CPU datapath
    logic        resp_valid;
    logic [15:0] resp_rdata;

    // data memory port
    logic        mem_write_enable;
    logic        mem_read_enable;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;

    modport master (
        input  req_valid,
        input  req_we,
        input  req_byte,
        input  req_addr,
        input  req_wdata,
        input  mem_rdata,
        output req_ready,
        output resp_valid,
        output resp_rdata,
        output mem_write_enable,
        output mem_read_enable,
        output mem_addr,
        output mem_wdata
    );

    modport slave (
        output req_valid,
        output req_we,
        output req_byte,
        output req_addr,
        output req_wdata,
        output mem_rdata,
        input  req_ready,
        input  resp_valid,
        input  resp_rdata,
        input  mem_write_enable,
        input  mem_read_enable,
        input  mem_addr,
        input  mem_wdata
    );
endinterface

// File: rtl/mem_access_unit.sv
// Memory access unit: takes one load/store at a time from the CPU datapath and
// sequences the data memory enables. The memory only writes whole words, so a
// byte store reads the word first and writes it back with the low byte merged
// (read-modify-write). Every output comes straight from a flop.
module mem_access_unit #(
    parameter int RD_LATENCY = 1    // memory read latency in cycles, 1..7
) (
    input  logic         clk,
    input  logic         reset,
    mem_access_if.master bus
);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WAIT,
        WR,
        RESP
    } state_t;

    // WAIT counts down from this value; the edge that sees zero is the one
    // where the memory's read data is valid.
    localparam logic [2:0] WAIT_LAST = 3'(RD_LATENCY - 1);

    state_t      state_reg;
    logic [2:0]  lat_cnt_reg;

    // latched request
    logic        we_reg;
    logic        byte_reg;
    logic [15:0] addr_reg;
    logic [7:0]  wdata_lo_reg;   // only the low byte is needed after accept

    // registered outputs
    logic        req_ready_reg;
    logic        resp_valid_reg;
    logic [15:0] resp_rdata_reg;
    logic        mem_we_reg;
    logic        mem_re_reg;
    logic [15:0] mem_addr_reg;
    logic [15:0] mem_wdata_reg;

    // Sequencer: each transition also loads the outputs for the state being
    // entered, so the enables and resp_valid line up with their state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            lat_cnt_reg    <= 3'd0;
            we_reg         <= 1'b0;
            byte_reg       <= 1'b0;
            addr_reg       <= 16'h0000;
            wdata_lo_reg   <= 8'h00;
            req_ready_reg  <= 1'b1;
            resp_valid_reg <= 1'b0;
            resp_rdata_reg <= 16'h0000;
            mem_we_reg     <= 1'b0;
            mem_re_reg     <= 1'b0;
            mem_addr_reg   <= 16'h0000;
            mem_wdata_reg  <= 16'h0000;
        end else begin
            // enables and the response are single-cycle pulses
            mem_we_reg     <= 1'b0;
            mem_re_reg     <= 1'b0;
            resp_valid_reg <= 1'b0;

            case (state_reg)
                IDLE: begin
                    if (bus.req_valid) begin
                        we_reg        <= bus.req_we;
                        byte_reg      <= bus.req_byte;
                        addr_reg      <= bus.req_addr;
                        wdata_lo_reg  <= bus.req_wdata[7:0];
                        req_ready_reg <= 1'b0;
                        mem_addr_reg  <= bus.req_addr;
                        if (bus.req_we && !bus.req_byte) begin
                            // word store needs no read
                            state_reg     <= WR;
                            mem_we_reg    <= 1'b1;
                            mem_wdata_reg <= bus.req_wdata;
                        end else begin
                            // load, or the read half of a byte store
                            state_reg  <= RD;
                            mem_re_reg <= 1'b1;
                        end
                    end
                end

                RD: begin
                    state_reg   <= WAIT;
                    lat_cnt_reg <= WAIT_LAST;
                end

                WAIT: begin
                    if (lat_cnt_reg == 3'd0) begin
                        if (we_reg) begin
                            // merge new low byte over the word just read
                            state_reg     <= WR;
                            mem_we_reg    <= 1'b1;
                            mem_addr_reg  <= addr_reg;
                            mem_wdata_reg <= {bus.mem_rdata[15:8], wdata_lo_reg};
                        end else begin
                            state_reg      <= RESP;
                            resp_valid_reg <= 1'b1;
                            resp_rdata_reg <= byte_reg ? {8'h00, bus.mem_rdata[7:0]}
                                                       : bus.mem_rdata;
                        end
                    end else begin
                        lat_cnt_reg <= lat_cnt_reg - 3'd1;
                    end
                end

                WR: begin
                    state_reg      <= RESP;
                    resp_valid_reg <= 1'b1;
                    resp_rdata_reg <= 16'h0000;
                end

                RESP: begin
                    state_reg     <= IDLE;
                    req_ready_reg <= 1'b1;
                end

                default: begin
                    state_reg     <= IDLE;
                    req_ready_reg <= 1'b1;
                end
            endcase
        end
    end

    assign bus.req_ready        = req_ready_reg;
    assign bus.resp_valid       = resp_valid_reg;
    assign bus.resp_rdata       = resp_rdata_reg;
    assign bus.mem_write_enable = mem_we_reg;
    assign bus.mem_read_enable  = mem_re_reg;
    assign bus.mem_addr         = mem_addr_reg;
    assign bus.mem_wdata        = mem_wdata_reg;

endmodule
